// File: rtl/addx_pkg.sv
// Shared types, widths and helpers for the ADDX issue controller.
package addx_pkg;

  localparam int unsigned ADDX_PERF_CNT_W    = 32;
  localparam int unsigned ADDX_XLEN          = 64;
  localparam int unsigned ADDX_TRANS_ID_BITS = 3;

  typedef logic [ADDX_PERF_CNT_W-1:0] addx_perf_cnt_t;

  typedef struct packed {
    logic [ADDX_XLEN-1:0]          operand_a;
    logic [ADDX_XLEN-1:0]          operand_b;
    logic [ADDX_TRANS_ID_BITS-1:0] trans_id;
  } addx_fu_data_t;

  // Bit width able to index n items; never below 1 so one-entry ranges stay legal.
  function automatic int unsigned addx_clog2w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic bit addx_depth_legal(input int unsigned depth);
    return (depth >= 2) && ((depth & (depth - 1)) == 0);
  endfunction

endpackage

// File: rtl/addx_op_fifo.sv
// DEPTH-entry in-order operand FIFO; pointers wrap naturally since DEPTH is a power of two.
module addx_op_fifo import addx_pkg::*; #(
  parameter type         fu_data_t = addx_fu_data_t,
  parameter int unsigned DEPTH     = 2,
  localparam int unsigned CNT_W    = addx_clog2w(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic             push_i,
  input  fu_data_t         data_i,
  input  logic             pop_i,
  output fu_data_t         head_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o
);

  localparam int unsigned PTR_W = addx_clog2w(DEPTH);

  fu_data_t         mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = empty_o ? fu_data_t'('0) : mem_q[rd_ptr_q];

  assign do_push = push_i && !full_o && !flush_i;
  assign do_pop  = pop_i && !empty_o && !flush_i;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload storage needs no reset: entries are only visible while counted.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/addx_issue_ctrl.sv
// ADDX issue controller: operand FIFO, registered writeback and handshakes.
// Define ADDX_ISSUE_PERF_EN to build the issued/completed/flushed performance counters.
module addx_issue_ctrl import addx_pkg::*; #(
  parameter int unsigned XLEN          = ADDX_XLEN,
  parameter int unsigned TRANS_ID_BITS = ADDX_TRANS_ID_BITS,
  parameter type         fu_data_t     = addx_fu_data_t,
  parameter int unsigned DEPTH         = 2
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     flush_i,
  input  fu_data_t                 fu_data_i,
  input  logic                     addx_valid_i,
  output logic                     addx_ready_o,
  output fu_data_t                 accel_fu_data_o,
  input  logic [XLEN-1:0]          accel_result_i,
  output logic [XLEN-1:0]          addx_result_o,
  output logic [TRANS_ID_BITS-1:0] addx_trans_id_o,
  output logic                     addx_valid_o,
  input  logic                     wb_ready_i,
  output addx_perf_cnt_t           issued_cnt_o,
  output addx_perf_cnt_t           completed_cnt_o,
  output addx_perf_cnt_t           flushed_cnt_o
);

  localparam int unsigned CNT_W       = addx_clog2w(DEPTH + 1);
  localparam bit          DEPTH_LEGAL = addx_depth_legal(DEPTH);

  if (!DEPTH_LEGAL) begin : g_depth_chk
    $error("addx_issue_ctrl: DEPTH must be a power of two and at least 2");
  end

  logic                     fifo_full, fifo_empty;
  logic [CNT_W-1:0]         fifo_count;
  logic                     push, load;
  logic                     valid_q, valid_d;
  logic [XLEN-1:0]          result_q, result_d;
  logic [TRANS_ID_BITS-1:0] tid_q, tid_d;

  assign addx_ready_o = (fifo_count < CNT_W'(DEPTH));
  assign push         = addx_valid_i && !fifo_full && !flush_i;
  assign load         = !fifo_empty && (!valid_q || wb_ready_i) && !flush_i;

  addx_op_fifo #(
    .fu_data_t (fu_data_t),
    .DEPTH     (DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .flush_i (flush_i),
    .push_i  (push),
    .data_i  (fu_data_i),
    .pop_i   (load),
    .head_o  (accel_fu_data_o),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // Flush beats load beats drain; result and trans_id only change on a load.
  always_comb begin
    valid_d  = valid_q;
    result_d = result_q;
    tid_d    = tid_q;
    if (flush_i) begin
      valid_d = 1'b0;
    end else if (load) begin
      valid_d  = 1'b1;
      result_d = accel_result_i;
      tid_d    = TRANS_ID_BITS'(accel_fu_data_o.trans_id);
    end else if (valid_q && wb_ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q  <= 1'b0;
      result_q <= '0;
      tid_q    <= '0;
    end else begin
      valid_q  <= valid_d;
      result_q <= result_d;
      tid_q    <= tid_d;
    end
  end

  assign addx_valid_o    = valid_q;
  assign addx_result_o   = result_q;
  assign addx_trans_id_o = tid_q;

`ifdef ADDX_ISSUE_PERF_EN
  addx_perf_cnt_t issued_q, issued_d;
  addx_perf_cnt_t completed_q, completed_d;
  addx_perf_cnt_t flushed_q, flushed_d;
  logic           wb_hs;

  assign wb_hs = valid_q && wb_ready_i;

  // A result handed off during a flush cycle is completed, so only an unaccepted one is flushed.
  always_comb begin
    issued_d    = issued_q + ADDX_PERF_CNT_W'(push);
    completed_d = completed_q + ADDX_PERF_CNT_W'(wb_hs);
    flushed_d   = flushed_q;
    if (flush_i) begin
      flushed_d = flushed_q + ADDX_PERF_CNT_W'(fifo_count)
                + ADDX_PERF_CNT_W'(valid_q && !wb_ready_i);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      issued_q    <= '0;
      completed_q <= '0;
      flushed_q   <= '0;
    end else begin
      issued_q    <= issued_d;
      completed_q <= completed_d;
      flushed_q   <= flushed_d;
    end
  end

  assign issued_cnt_o    = issued_q;
  assign completed_cnt_o = completed_q;
  assign flushed_cnt_o   = flushed_q;
`else
  assign issued_cnt_o    = '0;
  assign completed_cnt_o = '0;
  assign flushed_cnt_o   = '0;
`endif

endmodule

// File: tb/tb_addx_issue_ctrl.sv
// Directed and scoreboarded bench for addx_issue_ctrl with a saturating-add accelerator model.
module tb_addx_issue_ctrl;
  import addx_pkg::*;

  typedef struct {
    logic [63:0] res;
    logic [2:0]  id;
  } sbEntry_t;

  logic           clk = 1'b0;
  logic           rstN;
  logic           flush = 1'b0;
  logic           addxValid = 1'b0;
  logic           wbReady = 1'b0;
  addx_fu_data_t  fuData = '0;
  addx_fu_data_t  accelFuData;
  logic [63:0]    accelResult;
  logic [63:0]    result;
  logic [2:0]     transId;
  logic           ready;
  logic           validOut;
  addx_perf_cnt_t issuedCnt, completedCnt, flushedCnt;

  int       assertCount = 0;
  int       failCount = 0;
  sbEntry_t sb[$];

  always #5 clk = ~clk;

  addx_issue_ctrl #(
    .XLEN          (64),
    .TRANS_ID_BITS (3),
    .fu_data_t     (addx_fu_data_t),
    .DEPTH         (2)
  ) dut (
    .clk_i           (clk),
    .rst_ni          (rstN),
    .flush_i         (flush),
    .fu_data_i       (fuData),
    .addx_valid_i    (addxValid),
    .addx_ready_o    (ready),
    .accel_fu_data_o (accelFuData),
    .accel_result_i  (accelResult),
    .addx_result_o   (result),
    .addx_trans_id_o (transId),
    .addx_valid_o    (validOut),
    .wb_ready_i      (wbReady),
    .issued_cnt_o    (issuedCnt),
    .completed_cnt_o (completedCnt),
    .flushed_cnt_o   (flushedCnt)
  );

  function automatic logic [63:0] satAdd(input logic [63:0] a, input logic [63:0] b);
    logic [63:0] s;
    s = a + b;
    if ((a[63] == b[63]) && (s[63] != a[63]))
      s = a[63] ? 64'h8000_0000_0000_0000 : 64'h7FFF_FFFF_FFFF_FFFF;
    return s;
  endfunction

  // Combinational accelerator stand-in working on whatever head the controller presents.
  always_comb accelResult = satAdd(accelFuData.operand_a, accelFuData.operand_b);

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic [63:0] a, input logic [63:0] b,
                               input logic [2:0] id);
    addxValid       = v;
    fuData.operand_a = a;
    fuData.operand_b = b;
    fuData.trans_id  = id;
  endtask

  // Retire one writeback handshake against the scoreboard.
  task automatic retire(input string tag);
    sbEntry_t e;
    if (validOut && wbReady) begin
      if (sb.size() == 0) begin
        checkOutput({tag, "_underflow"}, 64'(validOut), 64'd0);
      end else begin
        e = sb.pop_front();
        checkOutput({tag, "_result"}, result, e.res);
        checkOutput({tag, "_id"}, 64'(transId), 64'(e.id));
      end
    end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int pushes;
    int cycles;
    logic [63:0] ra, rb;
    logic [2:0]  rid;

    rstN = 1'b1;
    #2 rstN = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    $display("[TB] reset state");
    checkOutput("rst_valid", 64'(validOut), 64'd0);
    checkOutput("rst_result", result, 64'd0);
    checkOutput("rst_id", 64'(transId), 64'd0);
    checkOutput("rst_ready", 64'(ready), 64'd1);
    checkOutput("rst_accel", accelFuData.operand_a, 64'd0);
    rstN = 1'b1;

    $display("[TB] single op latency");
    wbReady = 1'b1;
    applyStimulus(1'b1, 64'd5, 64'd7, 3'd3);
    step();
    applyStimulus(1'b0, 64'd0, 64'd0, 3'd0);
    checkOutput("lat_t1_valid", 64'(validOut), 64'd0);
    step();
    checkOutput("lat_t2_valid", 64'(validOut), 64'd1);
    checkOutput("lat_t2_result", result, 64'd12);
    checkOutput("lat_t2_id", 64'(transId), 64'd3);
    step();
    checkOutput("lat_t3_valid", 64'(validOut), 64'd0);
    checkOutput("lat_t3_hold", result, 64'd12);

    $display("[TB] saturation back-to-back");
    applyStimulus(1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 3'd1);
    step();
    applyStimulus(1'b1, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 3'd2);
    step();
    applyStimulus(1'b0, 64'd0, 64'd0, 3'd0);
    checkOutput("sat1_valid", 64'(validOut), 64'd1);
    checkOutput("sat1_result", result, 64'h7FFF_FFFF_FFFF_FFFF);
    checkOutput("sat1_id", 64'(transId), 64'd1);
    step();
    checkOutput("sat2_valid", 64'(validOut), 64'd1);
    checkOutput("sat2_result", result, 64'h8000_0000_0000_0000);
    checkOutput("sat2_id", 64'(transId), 64'd2);
    step();
    checkOutput("sat_done", 64'(validOut), 64'd0);

    $display("[TB] writeback backpressure");
    wbReady = 1'b0;
    applyStimulus(1'b1, 64'd40, 64'd4, 3'd4);
    step();
    applyStimulus(1'b1, 64'd50, 64'd5, 3'd5);
    step();
    applyStimulus(1'b1, 64'd60, 64'd6, 3'd6);
    checkOutput("bp_ready_one", 64'(ready), 64'd1);
    step();
    applyStimulus(1'b0, 64'd0, 64'd0, 3'd0);
    checkOutput("bp_full_ready", 64'(ready), 64'd0);
    checkOutput("bp_held_valid", 64'(validOut), 64'd1);
    checkOutput("bp_held_id", 64'(transId), 64'd4);
    step();
    checkOutput("bp_hold_result", result, 64'd44);
    checkOutput("bp_hold_id", 64'(transId), 64'd4);
    wbReady = 1'b1;
    step();
    checkOutput("bp_id5", 64'(transId), 64'd5);
    checkOutput("bp_res5", result, 64'd55);
    checkOutput("bp_ready_back", 64'(ready), 64'd1);
    step();
    checkOutput("bp_id6", 64'(transId), 64'd6);
    checkOutput("bp_res6", result, 64'd66);
    checkOutput("bp_valid6", 64'(validOut), 64'd1);
    step();
    checkOutput("bp_drained", 64'(validOut), 64'd0);

    $display("[TB] flush with buffered ops");
    wbReady = 1'b0;
    applyStimulus(1'b1, 64'd1, 64'd7, 3'd0);
    step();
    applyStimulus(1'b1, 64'd1, 64'd8, 3'd1);
    step();
    applyStimulus(1'b1, 64'd1, 64'd9, 3'd2);
    step();
    checkOutput("fl_pre_ready", 64'(ready), 64'd0);
    checkOutput("fl_pre_valid", 64'(validOut), 64'd1);
    flush = 1'b1;
    applyStimulus(1'b1, 64'd9, 64'd9, 3'd7);
    step();
    flush = 1'b0;
    applyStimulus(1'b0, 64'd0, 64'd0, 3'd0);
    checkOutput("fl_valid", 64'(validOut), 64'd0);
    checkOutput("fl_ready", 64'(ready), 64'd1);
    checkOutput("fl_empty_head", accelFuData.operand_b, 64'd0);
`ifdef ADDX_ISSUE_PERF_EN
    checkOutput("fl_perf_flushed", 64'(flushedCnt), 64'd3);
    checkOutput("fl_perf_issued", 64'(issuedCnt), 64'd9);
    checkOutput("fl_perf_completed", 64'(completedCnt), 64'd6);
`endif
    wbReady = 1'b1;
    step();
    checkOutput("fl_no_wb1", 64'(validOut), 64'd0);
    step();
    checkOutput("fl_no_wb2", 64'(validOut), 64'd0);

    $display("[TB] async reset mid-stream");
    wbReady = 1'b0;
    applyStimulus(1'b1, 64'd3, 64'd3, 3'd1);
    step();
    applyStimulus(1'b1, 64'd4, 64'd4, 3'd2);
    step();
    applyStimulus(1'b0, 64'd0, 64'd0, 3'd0);
    checkOutput("ar_pre_valid", 64'(validOut), 64'd1);
    #2 rstN = 1'b0;
    #1;
    checkOutput("ar_valid", 64'(validOut), 64'd0);
    checkOutput("ar_ready", 64'(ready), 64'd1);
    checkOutput("ar_result", result, 64'd0);
`ifdef ADDX_ISSUE_PERF_EN
    checkOutput("ar_perf_issued", 64'(issuedCnt), 64'd0);
`endif
    step();
    rstN = 1'b1;
    wbReady = 1'b1;
    applyStimulus(1'b1, 64'd1, 64'd2, 3'd5);
    step();
    applyStimulus(1'b0, 64'd0, 64'd0, 3'd0);
    checkOutput("ar_t1_valid", 64'(validOut), 64'd0);
    step();
    checkOutput("ar_t2_valid", 64'(validOut), 64'd1);
    checkOutput("ar_t2_result", result, 64'd3);
    checkOutput("ar_t2_id", 64'(transId), 64'd5);
    step();
    checkOutput("ar_t3_valid", 64'(validOut), 64'd0);

    $display("[TB] random stream");
    pushes = 0;
    cycles = 0;
    while (pushes < 1000 && cycles < 20000) begin
      ra  = {$urandom(), $urandom()};
      rb  = {$urandom(), $urandom()};
      rid = 3'($urandom_range(0, 7));
      applyStimulus($urandom_range(0, 3) != 0, ra, rb, rid);
      wbReady = ($urandom_range(0, 3) != 0);
`ifdef ADDX_ISSUE_PERF_EN
      checkOutput("rand_perf_invariant", 64'(issuedCnt),
                  64'(completedCnt) + 64'(flushedCnt) + 64'(sb.size()));
`endif
      retire("rand");
      if (addxValid && ready) begin
        sb.push_back('{res: satAdd(ra, rb), id: rid});
        pushes++;
      end
      step();
      cycles++;
    end
    checkOutput("rand_pushes", 64'(pushes), 64'd1000);

    applyStimulus(1'b0, 64'd0, 64'd0, 3'd0);
    wbReady = 1'b1;
    cycles = 0;
    while (sb.size() > 0 && cycles < 20) begin
      retire("drain");
      step();
      cycles++;
    end
    checkOutput("sb_drain", 64'(sb.size()), 64'd0);
    checkOutput("drain_valid", 64'(validOut), 64'd0);
`ifdef ADDX_ISSUE_PERF_EN
    checkOutput("perf_issued_total", 64'(issuedCnt), 64'd1001);
    checkOutput("perf_completed_total", 64'(completedCnt), 64'd1001);
`else
    checkOutput("perf_off_issued", 64'(issuedCnt), 64'd0);
    checkOutput("perf_off_completed", 64'(completedCnt), 64'd0);
    checkOutput("perf_off_flushed", 64'(flushedCnt), 64'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
